rv32_mh_decoder: RTL and testbench
==================================

# rv32_mh_decoder

Registered, multi-hart RV32I+Zicsr instruction decode stage with valid/ready handshake, per-hart flush and a two-entry skid buffer. It sits between the per-hart fetch stage and register-file read in the barrel pipeline, and accepts one instruction per cycle tagged with its hart ID. It emits the decoded fields (registers, immediate, shamt, CSR, zimm, fence masks, opcode enum, immediate type, trap) one cycle later. Optional per-hart illegal-instruction counters support debug.

## Interface
- NUM_HARTS, 8, hart count (power of two, ≥2); HW = $clog2(NUM_HARTS)
- PC_W, 32, width of PC tag carried alongside the instruction
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- in_valid / in_ready  in / out  1  input handshake; transfer when both high
- in_instr  in  32  rv32_instr_t word
- in_pc  in  PC_W  PC tag, passed through
- in_hart  in  HW  hart ID tag, passed through
- flush  in  NUM_HARTS  per-hart kill mask
- halt  in  1  freeze stage
- out_valid / out_ready  out / in  1  output handshake
- out_hart, out_pc  out  HW, PC_W  tags of the presented instruction
- rv_rs1, rv_rs2, rv_rd, rv_shamt, rv_zimm  out  5 each  decoded fields
- rv_imm  out  32  sign-extended immediate (rv32_imm_t)
- rv_csr  out  12; rv_fence_pred, rv_fence_succ  out  4 each
- rv_opcode  out  rv32_opcode_enum_t; rv_imm_decoded_type  out  rv32_type_enum_t
- instr_trap  out  1  illegal or unsupported encoding
- trap_cnt_sel  in  HW; trap_cnt  out  16  (only with DECODER_TRAP_CNT_EN)

## Operation
- Storage: output register (OUT) plus skid register (SKID). Each holds valid, hart, pc and decoded fields. Decode is combinational on in_instr and is registered on acceptance.
- Acceptance: in_ready = rst && !halt && !SKID.valid.
- Accepted word goes to OUT if OUT is empty or being drained this cycle; otherwise it goes to SKID.
- Drain: on out_valid && out_ready && !halt, OUT takes SKID if SKID is valid, else the incoming word, else it becomes empty.
- Ordering is strict FIFO across harts.
- Decode covers the RV32I base set plus FENCE, FENCE.I, ECALL, EBREAK, CSRRW/S/C[I] and MRET/WFI.
- Immediate formats I/S/B/U/J per the ISA. B/J immediates have bit0=0 and are sign-extended from bit 12/20. U immediates are instr[31:12]<<12. rv_imm is 0 for R-type.
- shamt = instr[24:20] for SLLI/SRLI/SRAI, else 0.
- SLLI with instr[25]=1, or non-zero funct7 other than SRAI/SUB/SRA, is illegal.
- Illegal word: instr_trap=1; rv_opcode = enum value 0; all field outputs 0; rv_imm_decoded_type = R-type value.
- Flush: every valid OUT/SKID entry whose hart bit is set in flush is invalidated that cycle. An input accepted the same cycle with flush[in_hart]=1 is consumed and dropped. Flush has priority over halt and over out_ready.
- Halt: no acceptance and no drain. OUT and SKID hold, so out_valid stays unchanged, except entries invalidated by flush.
- Reset: OUT/SKID invalid; all outputs 0; in_ready 0 while rst=0.

## Timing
- Latency: 1 cycle from accepted input to out_valid with matching fields.
- Throughput: 1 instruction/cycle with out_ready held high.
- Backpressure: with out_ready low, one further word is accepted into SKID. in_ready falls the next cycle and rises the cycle after SKID drains into OUT.
- Outputs change only on rising clk. They are held stable while out_valid && !out_ready (except flush).
- Reset taken mid-stream: all in-flight entries lost; in_ready=1 on the first cycle after rst returns high.

## Configuration
- DECODER_TRAP_CNT_EN defined:
  - NUM_HARTS 16-bit saturating counters increment when an entry with instr_trap=1 transfers out (not when flushed).
  - trap_cnt = counter[trap_cnt_sel], combinational read.
  - Counters clear on reset.
- Undefined: counters, trap_cnt_sel and trap_cnt ports are absent; no other behaviour changes.

## Test plan
- 0x00500093 (addi x1,x0,5), hart 3 -> next cycle out_valid=1, out_hart=3, rd=1, rs1=0, imm=5, I-type, trap=0.
- Back-to-back 0x0020A423 (sw x2,8(x1)), 0xFE000EE3 (beq x0,x0,-4), 0x123452B7 (lui x5,0x12345) -> imm 8/S, -4/B, 0x12345000/U, one per cycle, in order.
- 0x01F19193 (slli x3,x3,31) -> shamt=31, rd=rs1=3. 0xFFFFFFFF -> trap=1, all fields 0. With DECODER_TRAP_CNT_EN: trap_cnt for that hart =1.
- out_ready low for 3 cycles while feeding 3 words -> exactly 2 accepted, in_ready low from cycle 2; release -> both emerge in order, no loss or duplicate.
- OUT holds hart 2 and SKID holds hart 5; pulse flush=8'b0000_0100 -> only hart 5 entry emerges; halt asserted together with flush still invalidates.
- Drive rst low mid-stream with OUT and SKID full -> out_valid=0 and all outputs 0 next cycle; in_ready=1 one cycle after release.

Source files
------------

// File: rtl/rv32_mh_decoder.sv
// rv32_mh_decoder: registered multi-hart RV32I+Zicsr decode stage, 2-entry skid.
// Optional per-hart trap counters with `define DECODER_TRAP_CNT_EN.
package rv32_mh_decoder_pkg;
  typedef logic [31:0] rv32_instr_t;
  typedef logic [31:0] rv32_imm_t;

  typedef enum logic [5:0] {
    OP_ILLEGAL, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
    OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_FENCE, OP_FENCE_I, OP_ECALL, OP_EBREAK, OP_MRET, OP_WFI,
    OP_CSRRW, OP_CSRRS, OP_CSRRC, OP_CSRRWI, OP_CSRRSI, OP_CSRRCI
  } rv32_opcode_enum_t;

  typedef enum logic [2:0] {
    T_R, T_I, T_S, T_B, T_U, T_J
  } rv32_type_enum_t;

  typedef struct packed {
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [4:0]        zimm;
    rv32_imm_t         imm;
    logic [11:0]       csr;
    logic [3:0]        pred;
    logic [3:0]        succ;
    rv32_opcode_enum_t op;
    rv32_type_enum_t   typ;
    logic              trap;
  } dec_t;

  function automatic dec_t rv32_decode(input rv32_instr_t i);
    dec_t d;
    rv32_opcode_enum_t op;
    rv32_type_enum_t t;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    opc = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    op = OP_ILLEGAL;
    t = T_I;
    unique case (1'b1)
      opc == 7'b0110111: begin op = OP_LUI; t = T_U; end
      opc == 7'b0010111: begin op = OP_AUIPC; t = T_U; end
      opc == 7'b1101111: begin op = OP_JAL; t = T_J; end
      opc == 7'b1100111: if (f3 == 3'b000) op = OP_JALR;
      opc == 7'b1100011: begin
        t = T_B;
        case (f3)
          3'b000: op = OP_BEQ;
          3'b001: op = OP_BNE;
          3'b100: op = OP_BLT;
          3'b101: op = OP_BGE;
          3'b110: op = OP_BLTU;
          3'b111: op = OP_BGEU;
          default: op = OP_ILLEGAL;
        endcase
      end
      opc == 7'b0000011: begin
        case (f3)
          3'b000: op = OP_LB;
          3'b001: op = OP_LH;
          3'b010: op = OP_LW;
          3'b100: op = OP_LBU;
          3'b101: op = OP_LHU;
          default: op = OP_ILLEGAL;
        endcase
      end
      opc == 7'b0100011: begin
        t = T_S;
        case (f3)
          3'b000: op = OP_SB;
          3'b001: op = OP_SH;
          3'b010: op = OP_SW;
          default: op = OP_ILLEGAL;
        endcase
      end
      opc == 7'b0010011: begin
        case (f3)
          3'b000: op = OP_ADDI;
          3'b010: op = OP_SLTI;
          3'b011: op = OP_SLTIU;
          3'b100: op = OP_XORI;
          3'b110: op = OP_ORI;
          3'b111: op = OP_ANDI;
          3'b001: if (f7 == 7'h00) op = OP_SLLI;
          default: begin
            if (f7 == 7'h00) op = OP_SRLI;
            else if (f7 == 7'h20) op = OP_SRAI;
          end
        endcase
      end
      opc == 7'b0110011: begin
        t = T_R;
        if (f7 == 7'h00) begin
          case (f3)
            3'b000: op = OP_ADD;
            3'b001: op = OP_SLL;
            3'b010: op = OP_SLT;
            3'b011: op = OP_SLTU;
            3'b100: op = OP_XOR;
            3'b101: op = OP_SRL;
            3'b110: op = OP_OR;
            default: op = OP_AND;
          endcase
        end else if (f7 == 7'h20 && f3 == 3'b000) op = OP_SUB;
        else if (f7 == 7'h20 && f3 == 3'b101) op = OP_SRA;
      end
      opc == 7'b0001111: begin
        if (f3 == 3'b000) op = OP_FENCE;
        else if (f3 == 3'b001) op = OP_FENCE_I;
      end
      opc == 7'b1110011: begin
        case (f3)
          3'b000: begin
            if (i == 32'h0000_0073) op = OP_ECALL;
            else if (i == 32'h0010_0073) op = OP_EBREAK;
            else if (i == 32'h3020_0073) op = OP_MRET;
            else if (i == 32'h1050_0073) op = OP_WFI;
          end
          3'b001: op = OP_CSRRW;
          3'b010: op = OP_CSRRS;
          3'b011: op = OP_CSRRC;
          3'b101: op = OP_CSRRWI;
          3'b110: op = OP_CSRRSI;
          3'b111: op = OP_CSRRCI;
          default: op = OP_ILLEGAL;
        endcase
      end
      default: op = OP_ILLEGAL;
    endcase

    d = '0;
    d.trap = (op == OP_ILLEGAL);
    if (!d.trap) begin
      d.op = op;
      d.typ = t;
      if (t != T_S && t != T_B) d.rd = i[11:7];
      if (t != T_U && t != T_J) d.rs1 = i[19:15];
      if (t == T_R || t == T_S || t == T_B) d.rs2 = i[24:20];
      case (t)
        T_I: d.imm = {{20{i[31]}}, i[31:20]};
        T_S: d.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        T_B: d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        T_U: d.imm = {i[31:12], 12'h000};
        T_J: d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        default: d.imm = '0;
      endcase
      if (op inside {OP_SLLI, OP_SRLI, OP_SRAI}) d.shamt = i[24:20];
      if (op == OP_FENCE) begin
        d.pred = i[27:24];
        d.succ = i[23:20];
      end
      if (op inside {OP_CSRRW, OP_CSRRS, OP_CSRRC,
                     OP_CSRRWI, OP_CSRRSI, OP_CSRRCI}) begin
        d.csr = i[31:20];
        d.imm = '0;
      end
      // immediate CSR forms carry zimm in the rs1 slot
      if (op inside {OP_CSRRWI, OP_CSRRSI, OP_CSRRCI}) begin
        d.zimm = i[19:15];
        d.rs1 = '0;
      end
    end
    return d;
  endfunction
endpackage

module rv32_mh_decoder
  import rv32_mh_decoder_pkg::*;
#(
  parameter int NUM_HARTS = 8,
  parameter int PC_W = 32,
  localparam int HW = $clog2(NUM_HARTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [HW-1:0]     in_hart,
  input  logic [NUM_HARTS-1:0] flush,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [HW-1:0]     out_hart,
  output logic [PC_W-1:0]   out_pc,
  output logic [4:0]        rv_rs1,
  output logic [4:0]        rv_rs2,
  output logic [4:0]        rv_rd,
  output logic [4:0]        rv_shamt,
  output logic [4:0]        rv_zimm,
  output logic [31:0]       rv_imm,
  output logic [11:0]       rv_csr,
  output logic [3:0]        rv_fence_pred,
  output logic [3:0]        rv_fence_succ,
  output rv32_opcode_enum_t rv_opcode,
  output rv32_type_enum_t   rv_imm_decoded_type,
  output logic              instr_trap
`ifdef DECODER_TRAP_CNT_EN
  ,
  input  logic [HW-1:0]     trap_cnt_sel,
  output logic [15:0]       trap_cnt
`endif
);
  typedef struct packed {
    logic            v;
    logic [HW-1:0]   hart;
    logic [PC_W-1:0] pc;
    dec_t            d;
  } ent_t;

  ent_t out_q, skid_q, inc;
  logic o_keep, s_keep, in_ok, xfer, o_free;

  assign in_ready = rst && !halt && !skid_q.v;
  assign o_keep = out_q.v && !flush[out_q.hart];
  assign s_keep = skid_q.v && !flush[skid_q.hart];
  assign in_ok = in_valid && in_ready && !flush[in_hart];
  assign xfer = o_keep && out_ready && !halt;
  assign o_free = !o_keep || xfer;

  always_comb begin
    inc = '0;
    inc.v = in_ok;
    inc.hart = in_hart;
    inc.pc = in_pc;
    inc.d = rv32_decode(in_instr);
  end

  // flush wins over halt and drain; a flushed OUT is refilled from SKID
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q <= '0;
      skid_q <= '0;
    end else if (halt) begin
      out_q.v <= o_keep;
      skid_q.v <= s_keep;
    end else if (o_free) begin
      if (s_keep) begin
        out_q <= skid_q;
        skid_q.v <= 1'b0;
      end else begin
        if (in_ok) out_q <= inc;
        else out_q.v <= 1'b0;
        skid_q.v <= 1'b0;
      end
    end else if (!s_keep) begin
      if (in_ok) skid_q <= inc;
      else skid_q.v <= 1'b0;
    end
  end

  assign out_valid = out_q.v;
  assign out_hart = out_q.hart;
  assign out_pc = out_q.pc;
  assign rv_rs1 = out_q.d.rs1;
  assign rv_rs2 = out_q.d.rs2;
  assign rv_rd = out_q.d.rd;
  assign rv_shamt = out_q.d.shamt;
  assign rv_zimm = out_q.d.zimm;
  assign rv_imm = out_q.d.imm;
  assign rv_csr = out_q.d.csr;
  assign rv_fence_pred = out_q.d.pred;
  assign rv_fence_succ = out_q.d.succ;
  assign rv_opcode = out_q.d.op;
  assign rv_imm_decoded_type = out_q.d.typ;
  assign instr_trap = out_q.d.trap;

`ifdef DECODER_TRAP_CNT_EN
  logic [15:0] cnt_q [NUM_HARTS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int h = 0; h < NUM_HARTS; h++) cnt_q[h] <= '0;
    end else if (xfer && out_q.d.trap && cnt_q[out_q.hart] != 16'hFFFF) begin
      cnt_q[out_q.hart] <= cnt_q[out_q.hart] + 16'd1;
    end
  end

  assign trap_cnt = cnt_q[trap_cnt_sel];
`endif
endmodule

// File: tb/tb_rv32_mh_decoder.sv
// tb_rv32_mh_decoder: scoreboard bench for the multi-hart decode stage.
// Build with +define+DECODER_TRAP_CNT_EN to also cover the trap counters.
module tb_rv32_mh_decoder;
  import rv32_mh_decoder_pkg::*;

  localparam int NH = 8;
  localparam int HW = 3;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [HW-1:0] in_hart;
  logic [NH-1:0] flush;
  logic halt;
  logic out_valid, out_ready;
  logic [HW-1:0] out_hart;
  logic [31:0] out_pc;
  logic [4:0] rv_rs1, rv_rs2, rv_rd, rv_shamt, rv_zimm;
  logic [31:0] rv_imm;
  logic [11:0] rv_csr;
  logic [3:0] rv_fence_pred, rv_fence_succ;
  rv32_opcode_enum_t rv_opcode;
  rv32_type_enum_t rv_imm_decoded_type;
  logic instr_trap;
`ifdef DECODER_TRAP_CNT_EN
  logic [HW-1:0] trap_cnt_sel;
  logic [15:0] trap_cnt;
`endif

  always #5 clk = ~clk;

  rv32_mh_decoder #(.NUM_HARTS(NH), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_hart(in_hart),
    .flush(flush), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_hart(out_hart), .out_pc(out_pc),
    .rv_rs1(rv_rs1), .rv_rs2(rv_rs2), .rv_rd(rv_rd),
    .rv_shamt(rv_shamt), .rv_zimm(rv_zimm), .rv_imm(rv_imm),
    .rv_csr(rv_csr), .rv_fence_pred(rv_fence_pred),
    .rv_fence_succ(rv_fence_succ), .rv_opcode(rv_opcode),
    .rv_imm_decoded_type(rv_imm_decoded_type),
    .instr_trap(instr_trap)
`ifdef DECODER_TRAP_CNT_EN
    , .trap_cnt_sel(trap_cnt_sel), .trap_cnt(trap_cnt)
`endif
  );

  typedef struct {
    logic [HW-1:0] hart;
    logic [31:0] pc;
    logic [4:0] rd, rs1, rs2, shamt;
    logic [31:0] imm;
    rv32_opcode_enum_t op;
    rv32_type_enum_t typ;
    logic trap;
  } exp_t;

  exp_t sb[$];
  exp_t cur, pe;
  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int out_cnt = 0;
  int nc, a0, o0;
  logic [31:0] pc_ctr = 32'h1000;
  logic rdy [3];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(rv32_opcode_enum_t op, rv32_type_enum_t t,
                              int rd, int rs1, int rs2, int sh,
                              logic [31:0] imm);
    exp_t e;
    e.hart = '0;
    e.pc = '0;
    e.rd = 5'(rd);
    e.rs1 = 5'(rs1);
    e.rs2 = 5'(rs2);
    e.shamt = 5'(sh);
    e.imm = imm;
    e.op = op;
    e.typ = t;
    e.trap = (op == OP_ILLEGAL);
    return e;
  endfunction

  // model: decide at the falling edge what the next rising edge does
  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready && !halt && !flush[out_hart]) begin
        out_cnt++;
        chk("sb_nonempty", 64'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          pe = sb.pop_front();
          chk("hart", out_hart, pe.hart);
          chk("pc", out_pc, pe.pc);
          chk("rd", rv_rd, pe.rd);
          chk("rs1", rv_rs1, pe.rs1);
          chk("rs2", rv_rs2, pe.rs2);
          chk("shamt", rv_shamt, pe.shamt);
          chk("imm", rv_imm, pe.imm);
          chk("opcode", rv_opcode, pe.op);
          chk("type", rv_imm_decoded_type, pe.typ);
          chk("trap", instr_trap, pe.trap);
        end
      end
      for (int k = sb.size() - 1; k >= 0; k--)
        if (flush[sb[k].hart]) sb.delete(k);
      if (in_valid && in_ready && !flush[in_hart]) begin
        acc_cnt++;
        sb.push_back(cur);
      end
    end
  end

  task automatic present(input logic [31:0] ins, input int h,
                         input exp_t e);
    in_valid = 1'b1;
    in_instr = ins;
    in_hart = HW'(h);
    in_pc = pc_ctr;
    cur = e;
    cur.hart = HW'(h);
    cur.pc = pc_ctr;
    pc_ctr += 32'd4;
  endtask

  task automatic send(input logic [31:0] ins, input int h, input exp_t e,
                      output int n);
    logic ok;
    present(ins, h, e);
    n = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = in_ready;
      n++;
      @(posedge clk);
      #1;
    end
    chk("send_accept", ok, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc = '0;
    in_hart = '0;
    flush = '0;
    halt = 1'b0;
    out_ready = 1'b1;
`ifdef DECODER_TRAP_CNT_EN
    trap_cnt_sel = '0;
`endif
    idle(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_imm", rv_imm, 0);
    chk("rst_opcode", rv_opcode, 0);
    rst = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);
    idle(1);

    send(32'h00500093, 3, mk(OP_ADDI, T_I, 1, 0, 0, 0, 5), nc);
    chk("lat_valid", out_valid, 1);
    chk("lat_hart", out_hart, 3);
    idle(2);

    send(32'h0020A423, 0, mk(OP_SW, T_S, 0, 1, 2, 0, 8), nc);
    chk("thru_sw", nc, 1);
    send(32'hFE000EE3, 1, mk(OP_BEQ, T_B, 0, 0, 0, 0, 32'hFFFFFFFC), nc);
    chk("thru_beq", nc, 1);
    send(32'h123452B7, 2, mk(OP_LUI, T_U, 5, 0, 0, 0, 32'h12345000), nc);
    chk("thru_lui", nc, 1);
    send(32'h01F19193, 4, mk(OP_SLLI, T_I, 3, 3, 0, 31, 31), nc);
    send(32'hFFFFFFFF, 6, mk(OP_ILLEGAL, T_R, 0, 0, 0, 0, 0), nc);
    send(32'h02019193, 1, mk(OP_ILLEGAL, T_R, 0, 0, 0, 0, 0), nc);
    send(32'h002081B3, 7, mk(OP_ADD, T_R, 3, 1, 2, 0, 0), nc);
    send(32'h008000EF, 5, mk(OP_JAL, T_J, 1, 0, 0, 0, 8), nc);
    send(32'hFFF10113, 0, mk(OP_ADDI, T_I, 2, 2, 0, 0, 32'hFFFFFFFF), nc);
    send(32'h40325213, 2, mk(OP_SRAI, T_I, 4, 4, 0, 3, 32'h403), nc);
    idle(3);
`ifdef DECODER_TRAP_CNT_EN
    trap_cnt_sel = 3'd6;
    #1 chk("trap_cnt_h6", trap_cnt, 1);
    trap_cnt_sel = 3'd1;
    #1 chk("trap_cnt_h1", trap_cnt, 1);
    trap_cnt_sel = 3'd0;
    #1 chk("trap_cnt_h0", trap_cnt, 0);
`endif

    // backpressure: three words offered while out_ready is low
    out_ready = 1'b0;
    a0 = acc_cnt;
    present(32'h00100093, 1, mk(OP_ADDI, T_I, 1, 0, 0, 0, 1));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rdy[c] = in_ready;
      @(posedge clk);
      #1;
      if (rdy[c] && c == 0)
        present(32'h00200113, 2, mk(OP_ADDI, T_I, 2, 0, 0, 0, 2));
      else if (rdy[c] && c == 1)
        present(32'h00300193, 3, mk(OP_ADDI, T_I, 3, 0, 0, 0, 3));
    end
    in_valid = 1'b0;
    chk("bp_rdy0", rdy[0], 1);
    chk("bp_rdy1", rdy[1], 1);
    chk("bp_rdy2", rdy[2], 0);
    chk("bp_accepted", acc_cnt - a0, 2);
    o0 = out_cnt;
    out_ready = 1'b1;
    #1 chk("bp_rdy_release", in_ready, 0);
    idle(1);
    chk("bp_rdy_after", in_ready, 1);
    idle(3);
    chk("bp_emerged", out_cnt - o0, 2);

    // flush OUT (hart 2) while SKID holds hart 5
    out_ready = 1'b0;
    send(32'h00A00513, 2, mk(OP_ADDI, T_I, 10, 0, 0, 0, 10), nc);
    send(32'h00B00593, 5, mk(OP_ADDI, T_I, 11, 0, 0, 0, 11), nc);
    flush = 8'b0000_0100;
    idle(1);
    flush = '0;
    chk("fl_valid", out_valid, 1);
    chk("fl_hart", out_hart, 5);
    o0 = out_cnt;
    out_ready = 1'b1;
    idle(3);
    chk("fl_emerged", out_cnt - o0, 1);

    // flush during halt, then input dropped by same-cycle flush
    out_ready = 1'b0;
    send(32'h00C00613, 2, mk(OP_ADDI, T_I, 12, 0, 0, 0, 12), nc);
    send(32'h00D00693, 5, mk(OP_ADDI, T_I, 13, 0, 0, 0, 13), nc);
    halt = 1'b1;
    out_ready = 1'b1;
    flush = 8'b0010_0000;
    idle(1);
    flush = '0;
    chk("hf_valid", out_valid, 1);
    chk("hf_hart", out_hart, 2);
    chk("hf_in_ready", in_ready, 0);
    idle(1);
    chk("hf_hold", out_valid, 1);
    o0 = out_cnt;
    halt = 1'b0;
    idle(3);
    chk("hf_emerged", out_cnt - o0, 1);
    o0 = out_cnt;
    present(32'h00E00713, 7, mk(OP_ADDI, T_I, 14, 0, 0, 0, 14));
    flush = 8'b1000_0000;
    idle(1);
    in_valid = 1'b0;
    flush = '0;
    idle(3);
    chk("drop_in", out_cnt - o0, 0);

    // reset with OUT and SKID both full
    out_ready = 1'b0;
    send(32'h00F00793, 1, mk(OP_ADDI, T_I, 15, 0, 0, 0, 15), nc);
    send(32'h0020A423, 4, mk(OP_SW, T_S, 0, 1, 2, 0, 8), nc);
    rst = 1'b0;
    idle(1);
    chk("mr_valid", out_valid, 0);
    chk("mr_imm", rv_imm, 0);
    chk("mr_rd", rv_rd, 0);
    chk("mr_pc", out_pc, 0);
    chk("mr_in_ready", in_ready, 0);
    rst = 1'b1;
    #1 chk("mr_rel_ready", in_ready, 1);
    out_ready = 1'b1;
    o0 = out_cnt;
    send(32'h00500093, 0, mk(OP_ADDI, T_I, 1, 0, 0, 0, 5), nc);
    idle(3);
    chk("mr_resume", out_cnt - o0, 1);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
